// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receiver slice: the receive state
// encoding, the parity_mode encodings and the oversampling constants.
// No ports; imported by uart_rx_fifo.
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   localparam logic [1:0] PAR_NONE     = 2'b00;
   localparam logic [1:0] PAR_EVEN     = 2'b01;
   localparam logic [1:0] PAR_ODD      = 2'b10;
   localparam logic [1:0] PAR_NONE_ALT = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   // Only the two explicit modes carry a parity bit on the wire.
   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem
// Circular receive buffer with occupancy counter. Full and empty come from
// the level count, so the pointers can simply wrap modulo DEPTH.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   push   in   write wdata (ignored when full unless a pop happens too)
//   pop    in   remove head entry (ignored when empty)
//   wdata  in   entry to write
//   head   out  head entry, forced to 0 when empty
//   level  out  occupancy 0..DEPTH
//   full   out  level == DEPTH
//   empty  out  level == 0
module uart_rx_fifo_mem #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (level == '0);
   assign full    = (level == DEPTH_L);
   assign pop_ok  = pop & ~empty;
   // A full buffer still accepts a write when the head leaves in the same cycle.
   assign push_ok = push & (~full | pop_ok);
   assign head    = empty ? '0 : store[rd_ptr];

   // Storage needs no reset: the head output is masked while empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         store[wr_ptr] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// 16x oversampling UART receiver feeding a small receive FIFO.
// Optional feature macro: UART_RX_BREAK_DET_EN (break detection; when
// undefined break_det is tied low and a break arrives as 0x00 frames with
// framingerr set).
// Ports:
//   mclkx16     in   oversample clock, 16 ticks per bit
//   reset       in   synchronous active-high reset
//   rx          in   asynchronous serial input, idle high, LSB first
//   parity_mode in   00 none, 01 even, 10 odd, 11 none
//   read        in   active-low pop request, falling edge pops one entry
//   rdata       out  head-of-FIFO data (0 when empty)
//   rxrdy       out  FIFO non-empty
//   parityerr   out  head entry parity error
//   framingerr  out  head entry framing error
//   overrun     out  sticky frame-dropped flag, cleared by next pop
//   level       out  FIFO occupancy
//   break_det   out  one-cycle break pulse, coincident with the push
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          mclkx16,
   input  logic                          reset,
   input  logic                          rx,
   input  logic [1:0]                    parity_mode,
   input  logic                          read,
   output logic [DATA_BITS-1:0]          rdata,
   output logic                          rxrdy,
   output logic                          parityerr,
   output logic                          framingerr,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          break_det
);

`ifdef UART_RX_BREAK_DET_EN
   localparam bit BREAK_EN = 1'b1;
`else
   localparam bit BREAK_EN = 1'b0;
`endif

   localparam int EW = DATA_BITS + 2;

   rx_state_t            state;
   rx_state_t            next_state;
   logic                 rx_meta;
   logic                 rx_sync;
   logic [3:0]           tick;
   logic [2:0]           bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic [1:0]           mode_q;
   logic                 par_err_q;
   logic                 par_bit_q;
   logic                 frame_err_q;
   logic                 stop_one_q;
   logic                 brk_wait;
   logic                 brk_q;
   logic                 push_q;
   logic [EW-1:0]        entry_q;
   logic                 mid_tick;
   logic                 bit_tick;
   logic                 last_bit;
   logic                 last_stop;
   logic                 break_frame;
   logic                 read_r;
   logic                 read_prev;
   logic                 pop_req;
   logic                 pop_ok;
   logic                 full;
   logic                 empty;
   logic                 dropped;
   logic [EW-1:0]        head;

   assign mid_tick  = (tick == 4'(MID_SAMPLE));
   assign bit_tick  = (tick == 4'(OVERSAMPLE - 1));
   assign last_bit  = (bit_cnt == 3'(DATA_BITS - 1));
   assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

   // A break is an all-zero frame including parity and every stop sample;
   // evaluated at the final stop sample, where rx_sync is that sample.
   assign break_frame = BREAK_EN && (shreg == '0) && !stop_one_q && !rx_sync &&
                        (!parity_enabled(mode_q) || !par_bit_q);

   // Two-flop synchronizer, preset to the idle line level.
   always_ff @(posedge mclkx16) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // Receive state register.
   always_ff @(posedge mclkx16) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; every decision uses the synchronized line.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (!rx_sync) next_state = START;
         end
         START: begin
            if (mid_tick) next_state = rx_sync ? IDLE : DATA;
         end
         DATA: begin
            if (bit_tick && last_bit) begin
               next_state = parity_enabled(mode_q) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_tick) next_state = STOP;
         end
         STOP: begin
            if (brk_wait) begin
               if (rx_sync) next_state = IDLE;
            end else if (bit_tick && last_stop) begin
               next_state = break_frame ? STOP : IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Frame datapath: tick counter, bit counters, shift register, error flags
   // and the registered FIFO entry that is pushed one cycle after the last
   // stop sample.
   always_ff @(posedge mclkx16) begin
      if (reset) begin
         tick        <= '0;
         bit_cnt     <= '0;
         stop_cnt    <= 1'b0;
         shreg       <= '0;
         mode_q      <= PAR_NONE;
         par_err_q   <= 1'b0;
         par_bit_q   <= 1'b0;
         frame_err_q <= 1'b0;
         stop_one_q  <= 1'b0;
         brk_wait    <= 1'b0;
         brk_q       <= 1'b0;
         push_q      <= 1'b0;
         entry_q     <= '0;
      end else begin
         push_q <= 1'b0;
         brk_q  <= 1'b0;
         case (state)
            IDLE: begin
               tick <= '0;
               if (!rx_sync) begin
                  mode_q      <= parity_mode;
                  bit_cnt     <= '0;
                  stop_cnt    <= 1'b0;
                  par_err_q   <= 1'b0;
                  par_bit_q   <= 1'b0;
                  frame_err_q <= 1'b0;
                  stop_one_q  <= 1'b0;
                  brk_wait    <= 1'b0;
               end
            end
            START: begin
               tick <= mid_tick ? '0 : tick + 1'b1;
            end
            DATA: begin
               tick <= tick + 1'b1;
               if (bit_tick) begin
                  shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            PARITY: begin
               tick <= tick + 1'b1;
               if (bit_tick) begin
                  par_bit_q <= rx_sync;
                  if (mode_q == PAR_EVEN) begin
                     par_err_q <= (^shreg) ^ rx_sync;
                  end else begin
                     par_err_q <= ~((^shreg) ^ rx_sync);
                  end
               end
            end
            STOP: begin
               tick <= tick + 1'b1;
               if (brk_wait) begin
                  if (rx_sync) brk_wait <= 1'b0;
               end else if (bit_tick) begin
                  stop_cnt <= stop_cnt + 1'b1;
                  if (!rx_sync) begin
                     frame_err_q <= 1'b1;
                  end else begin
                     stop_one_q <= 1'b1;
                  end
                  if (last_stop) begin
                     push_q  <= 1'b1;
                     entry_q <= {frame_err_q | ~rx_sync, par_err_q, shreg};
                     if (break_frame) begin
                        brk_q    <= 1'b1;
                        brk_wait <= 1'b1;
                     end
                  end
               end
            end
            default: tick <= '0;
         endcase
      end
   end

   // Falling-edge detector on the registered read strobe; a held-low read
   // produces a single pop.
   always_ff @(posedge mclkx16) begin
      if (reset) begin
         read_r    <= 1'b1;
         read_prev <= 1'b1;
      end else begin
         read_r    <= read;
         read_prev <= read_r;
      end
   end

   assign pop_req = read_prev & ~read_r;
   assign pop_ok  = pop_req & ~empty;
   assign dropped = push_q & full & ~pop_ok;

   // Sticky overrun: set when a frame is lost, cleared by a real pop.
   always_ff @(posedge mclkx16) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (pop_ok) begin
         overrun <= 1'b0;
      end else if (dropped) begin
         overrun <= 1'b1;
      end
   end

   uart_rx_fifo_mem #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (mclkx16),
      .reset (reset),
      .push  (push_q),
      .pop   (pop_req),
      .wdata (entry_q),
      .head  (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   assign rdata      = head[DATA_BITS-1:0];
   assign parityerr  = head[DATA_BITS];
   assign framingerr = head[DATA_BITS+1];
   assign rxrdy      = ~empty;
   assign break_det  = BREAK_EN ? brk_q : 1'b0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo (defaults: 8 data bits, 1 stop bit,
// FIFO depth 4). Expectations for the break sequence follow
// UART_RX_BREAK_DET_EN when the bench is built with it.
module tb_uart_rx_fifo;

   logic       clk;
   logic       reset;
   logic       rx;
   logic [1:0] parity_mode;
   logic       read;
   logic [7:0] rdata;
   logic       rxrdy;
   logic       parityerr;
   logic       framingerr;
   logic       overrun;
   logic [2:0] level;
   logic       break_det;

   int n_cmp  = 0;
   int n_fail = 0;
   int brk_count = 0;

   typedef struct {
      logic [7:0] data;
      logic [1:0] mode;
      logic [1:0] mode_mid;
      logic       pbit;
      logic       stopv;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs [7];

   uart_rx_fifo dut (
      .mclkx16     (clk),
      .reset       (reset),
      .rx          (rx),
      .parity_mode (parity_mode),
      .read        (read),
      .rdata       (rdata),
      .rxrdy       (rxrdy),
      .parityerr   (parityerr),
      .framingerr  (framingerr),
      .overrun     (overrun),
      .level       (level),
      .break_det   (break_det)
   );

   // 10 ns oversample clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count break pulses, sampled away from the active edge.
   always @(negedge clk) begin
      if (break_det) brk_count <= brk_count + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Send one frame: start, 8 data bits LSB first, optional parity, one stop.
   // parity_mode switches to mode_mid after the start bit; pop_at_stop
   // lowers read so the pop lands in the same cycle as the push.
   task automatic applyStimulus(input logic [7:0] data, input logic [1:0] mode,
                                input logic [1:0] mode_mid, input logic pbit,
                                input logic stopv, input logic pop_at_stop);
      parity_mode = mode;
      rx = 1'b0;
      waitCycles(16);
      parity_mode = mode_mid;
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         waitCycles(16);
      end
      if (mode == 2'b01 || mode == 2'b10) begin
         rx = pbit;
         waitCycles(16);
      end
      rx = stopv;
      if (pop_at_stop) begin
         waitCycles(10);
         read = 1'b0;
         waitCycles(6);
      end else begin
         waitCycles(16);
      end
      rx = 1'b1;
      waitCycles(24);
      read = 1'b1;
      waitCycles(4);
   endtask

   task automatic popOne();
      read = 1'b0;
      waitCycles(4);
      read = 1'b1;
      waitCycles(4);
   endtask

   task automatic doReset();
      reset = 1'b1;
      waitCycles(3);
      reset = 1'b0;
      waitCycles(2);
   endtask

   initial begin
      int brk_before;
      logic [7:0] exp_seq [4];

      //         data   mode   mid    p     stop  exp    perr  ferr
      vecs[0] = '{8'h0F, 2'b10, 2'b10, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0};
      vecs[1] = '{8'h0F, 2'b01, 2'b01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
      vecs[2] = '{8'hA5, 2'b00, 2'b00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
      vecs[3] = '{8'h3C, 2'b00, 2'b00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
      vecs[4] = '{8'h80, 2'b10, 2'b10, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
      vecs[5] = '{8'hC3, 2'b11, 2'b11, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
      vecs[6] = '{8'h33, 2'b01, 2'b00, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0};

      reset = 1'b1;
      rx = 1'b1;
      read = 1'b1;
      parity_mode = 2'b00;
      doReset();

      checkOutput("reset_level", 32'(level), 32'd0);
      checkOutput("reset_rxrdy", 32'(rxrdy), 32'd0);
      checkOutput("reset_rdata", 32'(rdata), 32'd0);
      checkOutput("reset_perr", 32'(parityerr), 32'd0);
      checkOutput("reset_ferr", 32'(framingerr), 32'd0);
      checkOutput("reset_overrun", 32'(overrun), 32'd0);
      checkOutput("reset_break", 32'(break_det), 32'd0);

      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].data, vecs[v].mode, vecs[v].mode_mid,
                       vecs[v].pbit, vecs[v].stopv, 1'b0);
         checkOutput($sformatf("v%0d_rdata", v), 32'(rdata), 32'(vecs[v].exp_data));
         checkOutput($sformatf("v%0d_perr", v), 32'(parityerr), 32'(vecs[v].exp_perr));
         checkOutput($sformatf("v%0d_ferr", v), 32'(framingerr), 32'(vecs[v].exp_ferr));
         checkOutput($sformatf("v%0d_rxrdy", v), 32'(rxrdy), 32'd1);
         checkOutput($sformatf("v%0d_level", v), 32'(level), 32'd1);
         popOne();
         checkOutput($sformatf("v%0d_level_after_pop", v), 32'(level), 32'd0);
         checkOutput($sformatf("v%0d_rdata_empty", v), 32'(rdata), 32'd0);
      end

      // Fill past capacity: 0x05 is dropped.
      for (int f = 1; f <= 5; f++) begin
         applyStimulus(8'(f), 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      end
      checkOutput("full_level", 32'(level), 32'd4);
      checkOutput("full_overrun", 32'(overrun), 32'd1);
      checkOutput("full_head", 32'(rdata), 32'h01);

      read = 1'b0;
      waitCycles(4);
      checkOutput("pop1_rdata", 32'(rdata), 32'h02);
      checkOutput("pop1_level", 32'(level), 32'd3);
      checkOutput("pop1_overrun", 32'(overrun), 32'd0);
      waitCycles(100);
      checkOutput("held_low_level", 32'(level), 32'd3);
      checkOutput("held_low_rdata", 32'(rdata), 32'h02);
      read = 1'b1;
      waitCycles(4);

      applyStimulus(8'h06, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      checkOutput("refill_level", 32'(level), 32'd4);

      // Push and pop in the same cycle while full.
      applyStimulus(8'h07, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
      checkOutput("pushpop_level", 32'(level), 32'd4);
      checkOutput("pushpop_overrun", 32'(overrun), 32'd0);
      exp_seq[0] = 8'h03;
      exp_seq[1] = 8'h04;
      exp_seq[2] = 8'h06;
      exp_seq[3] = 8'h07;
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("drain%0d_rdata", k), 32'(rdata), 32'(exp_seq[k]));
         popOne();
      end
      checkOutput("drain_level", 32'(level), 32'd0);
      popOne();
      checkOutput("empty_pop_level", 32'(level), 32'd0);
      checkOutput("empty_pop_rxrdy", 32'(rxrdy), 32'd0);

      // False start.
      rx = 1'b0;
      waitCycles(4);
      rx = 1'b1;
      waitCycles(40);
      checkOutput("false_start_level", 32'(level), 32'd0);

      // Reset in the middle of a frame.
      parity_mode = 2'b00;
      rx = 1'b0;
      waitCycles(16);
      rx = 1'b1;
      waitCycles(16);
      rx = 1'b0;
      waitCycles(18);
      reset = 1'b1;
      rx = 1'b1;
      waitCycles(3);
      reset = 1'b0;
      waitCycles(200);
      checkOutput("midreset_level", 32'(level), 32'd0);
      checkOutput("midreset_rxrdy", 32'(rxrdy), 32'd0);
      applyStimulus(8'h55, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      checkOutput("after_reset_rdata", 32'(rdata), 32'h55);
      checkOutput("after_reset_level", 32'(level), 32'd1);
      checkOutput("after_reset_ferr", 32'(framingerr), 32'd0);
      doReset();

      // Line held low for 12 bit times.
      brk_before = brk_count;
      parity_mode = 2'b00;
      rx = 1'b0;
      waitCycles(192);
      rx = 1'b1;
      waitCycles(200);
      checkOutput("break_head_rdata", 32'(rdata), 32'h00);
      checkOutput("break_head_ferr", 32'(framingerr), 32'd1);
`ifdef UART_RX_BREAK_DET_EN
      checkOutput("break_pulses", 32'(brk_count - brk_before), 32'd1);
      checkOutput("break_level", 32'(level), 32'd1);
`else
      checkOutput("break_pulses", 32'(brk_count - brk_before), 32'd0);
      checkOutput("break_level", 32'(level), 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
